// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC sequencer: picks the next PC from exception, predictor-failure flush,
// predicted target or PC+4, buffers redirects across IF stalls and blanks one cycle after each.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             if_stall_i,
  input  logic             pd_taken_i,
  input  logic [31:0]      pd_target_i,
  input  logic             pd_failed_i,
  input  logic [31:0]      pd_flush_pc_i,
  input  logic             exc_valid_i,
  input  logic [31:0]      exc_pc_i,
  output logic [31:0]      pc_o,
  output logic             if_flush_o,
  output logic             id_flush_o,
  output logic             redirect_pending_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;

  logic             accept_pd;
  logic             accepted;
  logic [31:0]      redir_tgt;

  // Predictor failures only count outside the wrong-path windows (HOLD and BLANK).
  assign accept_pd = pd_failed_i && (state_q == ST_RUN);
  assign accepted  = exc_valid_i || accept_pd;
  assign redir_tgt = exc_valid_i ? word_align(exc_pc_i) : word_align(pd_flush_pc_i);

  assign if_flush_o = rst_i && accepted;
  assign id_flush_o = rst_i && exc_valid_i;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;

    if (accept_pd && !exc_valid_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_HOLD: begin
        if (exc_valid_i) begin
          pend_pc_d = word_align(exc_pc_i);
        end
        if (!if_stall_i) begin
          pc_d      = exc_valid_i ? word_align(exc_pc_i) : pend_pc_q;
          pend_pc_d = 32'd0;
          pend_d    = 1'b0;
          state_d   = ST_BLANK;
        end
      end
      default: begin
        // RUN and BLANK share the update; only redirect acceptance differs.
        if (accepted) begin
          if (if_stall_i) begin
            pend_pc_d = redir_tgt;
            pend_d    = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            pc_d    = redir_tgt;
            state_d = ST_BLANK;
          end
        end else begin
          state_d = ST_RUN;
          if (!if_stall_i) begin
            pc_d = pd_taken_i ? word_align(pd_target_i) : pc_q + 32'd4;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      pend_pc_q <= 32'd0;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pc_o               = pc_q;
  assign redirect_pending_o = pend_q;
  assign mispredict_cnt_o   = cnt_q;

endmodule
